// File: rtl/rot_amount_finder.sv
// Recovers every rotate amount S with R == rotr(M,S) by testing one candidate per clock.
// A captured copy of M is rotated right once per cycle and compared against the captured R.
module rot_amount_finder #(
  parameter  int W  = 16,
  localparam int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  M,
  input  logic [W-1:0]  R,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] s_out,
  output logic          found,
  output logic [SW:0]   match_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [SW-1:0] K_LAST = SW'(W - 1);

  state_t        state, state_nxt;
  logic [W-1:0]  rot_q;
  logic [W-1:0]  ref_q;
  logic [SW-1:0] k;
  logic          accept;
  logic          hit;

  // Handshake flags are pure state decodes so they never depend on the inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign hit       = (rot_q == ref_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (k == K_LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q     <= '0;
      ref_q     <= '0;
      k         <= '0;
      s_out     <= '0;
      found     <= 1'b0;
      match_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rot_q     <= M;
            ref_q     <= R;
            k         <= '0;
            s_out     <= '0;
            found     <= 1'b0;
            match_cnt <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            match_cnt <= match_cnt + (SW+1)'(1);
            if (!found) begin
              s_out <= k;
              found <= 1'b1;
            end
          end
          rot_q <= {rot_q[0], rot_q[W-1:1]};
          // k stays at W-1 in DONE; it is cleared again on the next accept.
          if (k != K_LAST) k <= k + SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_amount_finder.sv
// Bench for rot_amount_finder: directed cases plus random words checked against a
// rotate-and-compare reference model.
module tb_rot_amount_finder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] M;
  logic [15:0] R;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  s_out;
  logic        found;
  logic [4:0]  match_cnt;

  int checks = 0;
  int errors = 0;

  rot_amount_finder #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .M(M), .R(R), .out_valid(out_valid), .out_ready(out_ready),
    .s_out(s_out), .found(found), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  // Reference: rotr(m,s)[i] = m[(i+s) mod 16] is the 16-bit window at offset s of {m,m}.
  function automatic logic [15:0] rotr(input logic [15:0] m, input int s);
    logic [31:0] d;
    d = {m, m};
    return d[s +: 16];
  endfunction

  function automatic void model(input logic [15:0] m, input logic [15:0] r,
                                output logic [3:0] s, output logic f, output logic [4:0] c);
    s = 4'd0; f = 1'b0; c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (rotr(m, i) == r) begin
        if (!f) s = 4'(i);
        f = 1'b1;
        c = c + 5'd1;
      end
    end
  endfunction

  // Full transaction from IDLE: accept, time the scan, check result, hold, handshake.
  task automatic run_txn(input string name, input logic [15:0] m, input logic [15:0] r,
                         input logic [3:0] es, input logic ef, input logic [4:0] ec,
                         input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_wait got=%b exp=1", name, in_ready);
    end
    M = m; R = r; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    M = 16'($urandom); R = 16'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); n++; @(negedge clk); end
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL %s latency got=%0d exp=16", name, n);
    end
    checks++;
    if (s_out !== es || found !== ef || match_cnt !== ec || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s result got s=%0d f=%b c=%0d rdy=%b exp s=%0d f=%b c=%0d rdy=0",
               name, s_out, found, match_cnt, in_ready, es, ef, ec);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; M = 16'($urandom); R = 16'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s_out !== es || found !== ef || match_cnt !== ec) begin
        errors++;
        $display("FAIL %s hold%0d got v=%b rdy=%b s=%0d f=%b c=%0d exp v=1 rdy=0 s=%0d f=%b c=%0d",
                 name, h, out_valid, in_ready, s_out, found, match_cnt, es, ef, ec);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake got v=%b rdy=%b exp v=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; M = '0; R = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s_out !== 4'd0 || found !== 1'b0 || match_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset got rdy=%b v=%b s=%0d f=%b c=%0d exp rdy=1 v=0 s=0 f=0 c=0",
               in_ready, out_valid, s_out, found, match_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_txn("t1_1234",   16'h1234, 16'h4123, 4'd4, 1'b1, 5'd1,  0);
    run_txn("t2_0001",   16'h0001, 16'h8000, 4'd1, 1'b1, 5'd1,  0);
    run_txn("t2_beef",   16'hBEEF, 16'hBEEF, 4'd0, 1'b1, 5'd1,  0);
    run_txn("t3_aaaa",   16'hAAAA, 16'h5555, 4'd1, 1'b1, 5'd8,  0);
    run_txn("t3_zero",   16'h0000, 16'h0000, 4'd0, 1'b1, 5'd16, 0);
    run_txn("t3_ones",   16'hFFFF, 16'hFFFF, 4'd0, 1'b1, 5'd16, 0);
    run_txn("t4_nomatch",16'h0000, 16'h0001, 4'd0, 1'b0, 5'd0,  0);
  endtask

  task automatic test_backpressure();
    run_txn("t5_hold", 16'hC001, 16'h8003, 4'd15, 1'b1, 5'd1, 5);
    run_txn("t5_next", 16'h00F0, 16'h0F00, 4'd12, 1'b1, 5'd1, 0);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    M = 16'hBEEF; R = 16'hBEEF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || s_out !== 4'd0 || found !== 1'b0 || match_cnt !== 5'd0) begin
      errors++;
      $display("FAIL t6_async_reset got v=%b rdy=%b s=%0d f=%b c=%0d exp v=0 rdy=1 s=0 f=0 c=0",
               out_valid, in_ready, s_out, found, match_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("t6_after", 16'h00F0, 16'h000F, 4'd4, 1'b1, 5'd1, 0);
  endtask

  task automatic test_random();
    logic [15:0] m, r;
    logic [3:0]  es;
    logic        ef;
    logic [4:0]  ec;
    for (int s = 0; s < 16; s++) begin
      m = 16'($urandom);
      r = rotr(m, s);
      model(m, r, es, ef, ec);
      run_txn($sformatf("rand_s%0d", s), m, r, es, ef, ec, 0);
    end
    for (int t = 0; t < 8; t++) begin
      m = 16'($urandom);
      r = (t % 2 == 0) ? 16'($urandom) : rotr(m, $urandom_range(0, 15));
      if (t == 3) m = {4{m[3:0]}};
      if (t == 3) r = rotr(m, 5);
      model(m, r, es, ef, ec);
      run_txn($sformatf("rand_mix%0d", t), m, r, es, ef, ec, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
